// File: rtl/bcd_disp_scan.sv
// Multiplexed 4-digit common-anode seven-segment scanner with a pending/shown double buffer.
// Define BCD_DISP_LZB_EN to enable leading-zero blanking of digits 3..1.
module bcd_disp_scan #(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   pend;
    logic [15:0]   shown;
    logic          boundary_d;
    logic          tick;
    logic          boundary;
    logic [3:0]    digit;
    logic          blank;

    assign tick     = (cnt == CNT_MAX);
    assign boundary = tick && (idx == 2'd3);
    assign digit    = shown[{idx, 2'b00} +: 4];

    // A digit is blanked only when it and every more significant shown digit are zero.
`ifdef BCD_DISP_LZB_EN
    always_comb begin
        blank = 1'b0;
        case (idx)
            2'd3:    blank = (shown[15:12] == 4'd0);
            2'd2:    blank = (shown[15:8] == 8'd0);
            2'd1:    blank = (shown[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Frame pulse is delayed one extra cycle so it coincides with digit 0 of the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= 2'd0;
            pend       <= 16'h0000;
            shown      <= 16'h0000;
            boundary_d <= 1'b0;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            frame      <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (load)
                pend <= bcd;
            if (tick)
                idx <= idx + 2'd1;
            if (boundary)
                shown <= pend;
            boundary_d <= boundary;
            frame      <= boundary_d;
            an         <= ~(4'b0001 << idx);
            seg        <= blank ? 7'b1111111 : decode(digit);
        end
    end

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Directed bench for bcd_disp_scan with CLK_DIV=4; expectations follow BCD_DISP_LZB_EN if defined.
module tb_bcd_disp_scan;

    localparam int D = 4;
`ifdef BCD_DISP_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct {
        logic [15:0]      bcd;
        logic [3:0][6:0]  seg;
        logic [3:0]       lzbMask;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd = 16'h0000;
    logic        load = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame;

    int total = 0;
    int bad = 0;

    vec_t vecs[6];
    vec_t zeroVec;

    bcd_disp_scan #(.CLK_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .load(load),
        .an(an), .seg(seg), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Holds load for exactly one rising edge.
    task automatic applyStimulus(input logic [15:0] value);
        bcd  = value;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic waitFrame();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (frame === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL frame_timeout actual=0 required=1 at %0t", $time);
        end
    endtask

    // Called in the frame-pulse cycle; walks all four slots and returns at the start of slot 3.
    task automatic checkFrame(input vec_t v, input string tag);
        logic [6:0] expSeg;
        for (int k = 0; k < 4; k++) begin
            expSeg = (LZB && v.lzbMask[k]) ? 7'b1111111 : v.seg[k];
            checkOutput($sformatf("%s_an%0d", tag, k), {12'd0, an}, {12'd0, ~(4'b0001 << k)});
            checkOutput($sformatf("%s_seg%0d", tag, k), {9'd0, seg}, {9'd0, expSeg});
            if (k == 0) begin
                @(negedge clk);
                checkOutput($sformatf("%s_frame_width", tag), {15'd0, frame}, 16'd0);
                repeat (D - 2) @(negedge clk);
            end else if (k < 3) begin
                repeat (D - 1) @(negedge clk);
            end
            if (k < 3) begin
                checkOutput($sformatf("%s_slot_end%0d", tag, k), {12'd0, an}, {12'd0, ~(4'b0001 << k)});
                @(negedge clk);
            end
        end
    endtask

    initial begin
        vecs[0] = '{16'h0123, {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000}, 4'b1000};
        vecs[1] = '{16'h00A5, {7'b1000000, 7'b1000000, 7'b0111111, 7'b0010010}, 4'b1100};
        vecs[2] = '{16'h0000, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1110};
        vecs[3] = '{16'h1000, {7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b0000};
        vecs[4] = '{16'h9876, {7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010}, 4'b0000};
        vecs[5] = '{16'h0504, {7'b1000000, 7'b0010010, 7'b1000000, 7'b0011001}, 4'b1000};
        zeroVec = vecs[2];

        // Reset held across clock edges.
        repeat (3) @(negedge clk);
        checkOutput("rst_an", {12'd0, an}, 16'h000F);
        checkOutput("rst_seg", {9'd0, seg}, 16'h007F);
        checkOutput("rst_frame", {15'd0, frame}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("first_an", {12'd0, an}, 16'h000E);
        checkOutput("first_seg", {9'd0, seg}, {9'd0, 7'b1000000});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].bcd);
            waitFrame();
            checkFrame(vecs[i], $sformatf("vec%0d", i));
        end

        // Load coinciding with the frame boundary must wait a full frame.
        applyStimulus(16'h0001);
        waitFrame();
        checkOutput("pre_bnd_seg0", {9'd0, seg}, {9'd0, 7'b1111001});
        repeat (4 * D - 2) @(negedge clk);
        applyStimulus(16'h0009);
        waitFrame();
        checkOutput("bnd_old_seg0", {9'd0, seg}, {9'd0, 7'b1111001});
        waitFrame();
        checkOutput("bnd_new_seg0", {9'd0, seg}, {9'd0, 7'b0010000});

        // Asynchronous reset during slot 2 with a load pending.
        repeat (2 * D) @(negedge clk);
        checkOutput("mid_an2", {12'd0, an}, 16'h000B);
        bcd  = 16'h0777;
        load = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_an", {12'd0, an}, 16'h000F);
        checkOutput("async_seg", {9'd0, seg}, 16'h007F);
        checkOutput("async_frame", {15'd0, frame}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load  = 1'b0;
        @(negedge clk);
        checkOutput("rerst_an", {12'd0, an}, 16'h000E);
        checkOutput("rerst_seg", {9'd0, seg}, {9'd0, 7'b1000000});
        waitFrame();
        checkFrame(zeroVec, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
